cpu_ctrl_seq: RTL and testbench



---
 rtl/cpu_ctrl_seq.sv | 145 ++++++++++++++
 tb/tb_cpu_ctrl_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_seq.sv
// Multi-cycle control sequencer for the accumulator CPU: fetch/decode/memory/execute
// with a bounded memory handshake and a sticky fault on timeout.
module cpu_ctrl_seq #(
    parameter int unsigned OPW     = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           z_flag,
    input  logic           mem_ready,
    output logic           mem_req,
    output logic           mem_we,
    output logic           addr_sel,
    output logic           ir_load,
    output logic           pc_inc,
    output logic           pc_load,
    output logic [2:0]     alu_op,
    output logic           acc_we,
    output logic           set_F,
    output logic           halted,
    output logic           fault,
    output logic           illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [OPW-1:0] OP_NOP   = OPW'(0);
    localparam logic [OPW-1:0] OP_LOAD  = OPW'(1);
    localparam logic [OPW-1:0] OP_STORE = OPW'(2);
    localparam logic [OPW-1:0] OP_ADD   = OPW'(3);
    localparam logic [OPW-1:0] OP_SUB   = OPW'(4);
    localparam logic [OPW-1:0] OP_AND   = OPW'(5);
    localparam logic [OPW-1:0] OP_JMP   = OPW'(6);
    localparam logic [OPW-1:0] OP_JZ    = OPW'(7);
    localparam logic [OPW-1:0] OP_JNZ   = OPW'(8);
    localparam logic [OPW-1:0] OP_HALT  = OPW'(15);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t         r_state;
    state_t         w_next;
    logic [7:0]     r_wait;
    logic [OPW-1:0] r_op;
    logic           w_timeout;

    assign w_timeout = (r_wait == WAIT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_wait  <= '0;
            r_op    <= '0;
        end else begin
            r_state <= w_next;
            // Any state change clears the counter, so entry to FETCH/MEM starts at zero.
            if (w_next != r_state)
                r_wait <= '0;
            else if (r_state == S_FETCH || r_state == S_MEM)
                r_wait <= r_wait + 8'd1;
            if (r_state == S_DECODE)
                r_op <= opcode;
        end
    end

    // Strobes are decoded from state and latched opcode; ir_load/pc_inc are additionally
    // qualified by mem_ready so the IR captures data on the completing edge.
    always_comb begin
        w_next   = r_state;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        addr_sel = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        alu_op   = 3'd0;
        acc_we   = 1'b0;
        set_F    = 1'b0;
        halted   = 1'b0;
        fault    = 1'b0;
        illegal  = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start)
                    w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_timeout) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: begin
                w_next = S_FETCH;
                case (opcode)
                    OP_NOP: ;
                    OP_LOAD, OP_STORE, OP_ADD, OP_SUB, OP_AND: w_next = S_MEM;
                    OP_JMP:  pc_load = 1'b1;
                    OP_JZ:   pc_load = z_flag;
                    OP_JNZ:  pc_load = ~z_flag;
                    OP_HALT: w_next = S_HALT;
                    default: illegal = 1'b1;
                endcase
            end
            S_MEM: begin
                mem_req  = 1'b1;
                addr_sel = 1'b1;
                mem_we   = (r_op == OP_STORE);
                if (mem_ready)
                    w_next = (r_op == OP_STORE) ? S_FETCH : S_EXEC;
                else if (w_timeout)
                    w_next = S_FAULT;
            end
            S_EXEC: begin
                acc_we = 1'b1;
                set_F  = 1'b1;
                w_next = S_FETCH;
                case (r_op)
                    OP_ADD:  alu_op = 3'd1;
                    OP_SUB:  alu_op = 3'd2;
                    OP_AND:  alu_op = 3'd3;
                    default: alu_op = 3'd0;
                endcase
            end
            S_HALT:  halted = 1'b1;
            S_FAULT: fault  = 1'b1;
            default: w_next = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Directed bench for cpu_ctrl_seq: a cycle-by-cycle vector table for the instruction
// mix, plus hand sequences for timeout fault and reset in the middle of an access.
module tb_cpu_ctrl_seq;

    localparam logic [13:0] MREQ = 14'h2000;
    localparam logic [13:0] MWE  = 14'h1000;
    localparam logic [13:0] ASEL = 14'h0800;
    localparam logic [13:0] IRL  = 14'h0400;
    localparam logic [13:0] PCI  = 14'h0200;
    localparam logic [13:0] PCL  = 14'h0100;
    localparam logic [13:0] ALU1 = 14'h0020;
    localparam logic [13:0] ALU2 = 14'h0040;
    localparam logic [13:0] ALU3 = 14'h0060;
    localparam logic [13:0] AWE  = 14'h0010;
    localparam logic [13:0] SETF = 14'h0008;
    localparam logic [13:0] HLT  = 14'h0004;
    localparam logic [13:0] FLT  = 14'h0002;
    localparam logic [13:0] ILL  = 14'h0001;
    localparam logic [13:0] FTCH = MREQ | IRL | PCI;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] opcode;
    logic       z_flag;
    logic       mem_ready;
    logic       mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load;
    logic [2:0] alu_op;
    logic       acc_we, set_F, halted, fault, illegal;
    logic [13:0] outs;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        logic        s;
        logic        r;
        logic        z;
        logic [3:0]  op;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];

    cpu_ctrl_seq #(.OPW(4), .TIMEOUT(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .opcode    (opcode),
        .z_flag    (z_flag),
        .mem_ready (mem_ready),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .addr_sel  (addr_sel),
        .ir_load   (ir_load),
        .pc_inc    (pc_inc),
        .pc_load   (pc_load),
        .alu_op    (alu_op),
        .acc_we    (acc_we),
        .set_F     (set_F),
        .halted    (halted),
        .fault     (fault),
        .illegal   (illegal)
    );

    assign outs = {mem_req, mem_we, addr_sel, ir_load, pc_inc, pc_load, alu_op,
                   acc_we, set_F, halted, fault, illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [13:0] exp);
        n_tests++;
        if (outs !== exp) begin
            n_fail++;
            $display("FAIL %s: outputs got %014b expected %014b", nm, outs, exp);
        end
    endtask

    // Called at posedge+1: drive inputs, compare at negedge, advance to next posedge+1.
    task automatic cyc(input string nm, input logic s, input logic r, input logic z,
                       input logic [3:0] op, input logic [13:0] exp);
        start = s; mem_ready = r; z_flag = z; opcode = op;
        @(negedge clk);
        chk(nm, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic s, input logic r, input logic z,
                       input logic [3:0] op, input logic [13:0] exp);
        vec_t v;
        v.s = s; v.r = r; v.z = z; v.op = op; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0; mem_ready = 1'b0; z_flag = 1'b0; opcode = 4'd0;
        #1;
        chk("reset_outputs", 14'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        //   s  r  z  op     expected
        add(0, 0, 0, 4'h0, 14'h0);                 // IDLE, no start
        add(1, 0, 0, 4'h0, 14'h0);                 // IDLE, start
        add(0, 1, 0, 4'h0, FTCH);                  // FETCH, start dropped
        add(0, 1, 0, 4'h1, 14'h0);                 // DECODE LOAD
        add(0, 1, 0, 4'h0, MREQ | ASEL);           // MEM
        add(0, 0, 0, 4'h0, AWE | SETF);            // EXEC LOAD alu=0
        add(0, 1, 0, 4'h0, FTCH);
        add(0, 0, 0, 4'h3, 14'h0);                 // DECODE ADD
        add(0, 1, 0, 4'h0, MREQ | ASEL);
        add(0, 0, 0, 4'h0, ALU1 | AWE | SETF);
        add(0, 1, 0, 4'h0, FTCH);
        add(0, 0, 0, 4'h4, 14'h0);                 // DECODE SUB
        add(0, 1, 0, 4'h0, MREQ | ASEL);
        add(0, 0, 0, 4'h0, ALU2 | AWE | SETF);
        add(0, 1, 1, 4'h0, FTCH);
        add(0, 0, 1, 4'h7, PCL);                   // JZ taken
        add(0, 1, 0, 4'h0, FTCH);
        add(0, 0, 0, 4'h7, 14'h0);                 // JZ not taken
        add(0, 1, 0, 4'h0, FTCH);
        add(0, 0, 0, 4'h8, PCL);                   // JNZ taken
        add(0, 1, 1, 4'h0, FTCH);
        add(0, 0, 1, 4'h8, 14'h0);                 // JNZ not taken
        add(0, 1, 0, 4'h0, FTCH);
        add(0, 0, 0, 4'h2, 14'h0);                 // DECODE STORE
        add(0, 0, 0, 4'h0, MREQ | MWE | ASEL);     // MEM wait
        add(0, 1, 0, 4'h0, MREQ | MWE | ASEL);     // MEM ready -> FETCH
        add(0, 0, 0, 4'h0, MREQ);                  // FETCH wait 1
        add(0, 0, 0, 4'h0, MREQ);                  // FETCH wait 2
        add(0, 0, 0, 4'h0, MREQ);                  // FETCH wait 3
        add(0, 1, 0, 4'h0, FTCH);                  // ready on last allowed cycle
        add(0, 0, 0, 4'hB, ILL);                   // illegal opcode
        add(0, 1, 0, 4'h0, FTCH);
        add(0, 0, 0, 4'h5, 14'h0);                 // DECODE AND
        add(0, 1, 0, 4'h0, MREQ | ASEL);
        add(0, 0, 0, 4'h0, ALU3 | AWE | SETF);
        add(0, 1, 0, 4'h0, FTCH);
        add(0, 1, 0, 4'h6, PCL);                   // JMP, mem_ready ignored
        add(0, 1, 0, 4'h0, FTCH);
        add(0, 0, 0, 4'h0, 14'h0);                 // NOP
        add(0, 1, 0, 4'h0, FTCH);
        add(0, 0, 0, 4'hF, 14'h0);                 // HALT decode
        add(1, 1, 0, 4'h0, HLT);
        add(1, 1, 0, 4'h0, HLT);

        do_reset();
        for (int i = 0; i < vecs.size(); i++)
            cyc($sformatf("vec%0d", i), vecs[i].s, vecs[i].r, vecs[i].z, vecs[i].op, vecs[i].exp);

        // Timeout in FETCH with TIMEOUT=4
        do_reset();
        cyc("to_idle", 1, 0, 0, 4'h0, 14'h0);
        for (int i = 0; i < 4; i++)
            cyc($sformatf("to_wait%0d", i), 0, 0, 0, 4'h0, MREQ);
        cyc("to_fault", 0, 0, 0, 4'h0, FLT);
        cyc("to_sticky", 1, 1, 0, 4'h0, FLT);

        // Reset asserted during a STORE memory access
        do_reset();
        cyc("rm_idle", 1, 0, 0, 4'h0, 14'h0);
        cyc("rm_fetch", 0, 1, 0, 4'h0, FTCH);
        cyc("rm_decode", 0, 0, 0, 4'h2, 14'h0);
        start = 1'b0; mem_ready = 1'b0; opcode = 4'h0;
        @(negedge clk);
        chk("rm_mem", MREQ | MWE | ASEL);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rm_async_clear", 14'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc("rm_idle_hold0", 0, 1, 0, 4'h0, 14'h0);
        cyc("rm_idle_hold1", 0, 1, 0, 4'h0, 14'h0);
        cyc("rm_restart", 1, 0, 0, 4'h0, 14'h0);
        cyc("rm_fetch2", 0, 0, 0, 4'h0, MREQ);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
